fp16_adds_const: RTL and testbench

- Pipelined IEEE-754 binary16 adder: adds a compile-time constant (default +2.0) to each streamed operand.
- Forward counterpart of the datapath's fp16 subtract-2 stage; restores values after an offset is removed.
- Sits between operand producers and the accumulator path.
- Valid/ready streaming interface, fixed 3-cycle latency, full backpressure support.

---
 rtl/fp16_pkg.sv | 29 ++
 rtl/fp16_adds_const_if.sv | 28 ++
 rtl/fp16_round_pack.sv | 47 ++++
 rtl/fp16_adds_const.sv | 181 ++++++++++++++++++
 tb/tb_fp16_adds_const.sv | 168 ++++++++++++++++
 5 files changed

// File: rtl/fp16_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fp16_pkg
// Description : Shared binary16 field widths, special encodings, the packed
//               operand struct and classification helpers.
// Revision    : 1.0 - initial release
// ============================================================================
package fp16_pkg;

    localparam int EXP_W = 5;
    localparam int MAN_W = 10;
    localparam int BIAS  = 15;

    localparam logic [15:0] FP16_QNAN = 16'h7E00;
    localparam logic [15:0] FP16_PINF = 16'h7C00;
    localparam logic [15:0] FP16_NINF = 16'hFC00;

    typedef struct packed {
        logic             sign;
        logic [EXP_W-1:0] exp;
        logic [MAN_W-1:0] man;
    } fp16_t;

    function automatic logic fp16_is_nan(input fp16_t x);
        return (x.exp == '1) && (x.man != '0);
    endfunction

endpackage
`default_nettype wire

// File: rtl/fp16_adds_const_if.sv
`default_nettype none
// ============================================================================
// Module      : fp16_adds_const_if
// Description : Valid/ready operand and result stream of the fp16 add-const
//               stage. master = producer/consumer side, slave = the adder.
// Revision    : 1.0 - initial release
// ============================================================================
interface fp16_adds_const_if #(
    parameter int DATA_WIDTH = 16
);
    logic                  en_add;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] val;
    logic [DATA_WIDTH-1:0] res;
    logic                  res_valid;
    logic                  res_ready;

    modport master (
        output en_add, val, res_ready,
        input  in_ready, res, res_valid
    );

    modport slave (
        input  en_add, val, res_ready,
        output in_ready, res, res_valid
    );
endinterface
`default_nettype wire

// File: rtl/fp16_round_pack.sv
`default_nettype none
// ============================================================================
// Module      : fp16_round_pack
// Description : Combinational round-to-nearest-even and binary16 packing of a
//               normalised 14-bit significand (hidden, 10 mantissa, g, r, s).
// Revision    : 1.0 - initial release
// ============================================================================
module fp16_round_pack
    import fp16_pkg::*;
(
    input  wire logic        i_sign,
    input  wire logic [5:0]  i_exp,
    input  wire logic [13:0] i_sig,
    input  wire logic        i_spec,
    input  wire logic [15:0] i_spec_val,
    output logic      [15:0] o_res
);

    localparam logic [5:0] c_exp_inf = 6'(2 * BIAS + 1);

    logic        w_round_up;
    logic [11:0] w_rnd;
    logic [10:0] w_man;
    logic [5:0]  w_exp;

    // Round on guard/round/sticky, renormalise on carry, then pack or saturate.
    always_comb begin
        w_round_up = i_sig[2] & (i_sig[1] | i_sig[0] | i_sig[3]);
        w_rnd      = {1'b0, i_sig[13:3]} + {11'd0, w_round_up};
        w_man      = w_rnd[10:0];
        w_exp      = i_exp;
        if (w_rnd[11]) begin
            w_man = w_rnd[11:1];
            w_exp = i_exp + 6'd1;
        end
        if (i_spec) begin
            o_res = i_spec_val;
        end else if (w_exp >= c_exp_inf) begin
            o_res = i_sign ? FP16_NINF : FP16_PINF;
        end else begin
            // A clear hidden bit can only occur at exponent 1: encode as subnormal.
            o_res = {i_sign, (w_man[10] ? w_exp[4:0] : 5'd0), w_man[9:0]};
        end
    end

endmodule
`default_nettype wire

// File: rtl/fp16_adds_const.sv
`default_nettype none
// ============================================================================
// Module      : fp16_adds_const
// Description : Three-stage pipelined binary16 adder computing val + ADD_CONST
//               on a valid/ready stream with a global stall.
// Revision    : 1.0 - initial release
// ============================================================================
module fp16_adds_const
    import fp16_pkg::*;
#(
    parameter int          DATA_WIDTH = 16,
    parameter logic [15:0] ADD_CONST  = 16'h4000
) (
    input  wire logic         clk,
    input  wire logic         reset_l,
    fp16_adds_const_if.slave  bus
);

    localparam fp16_t c_k = fp16_t'(ADD_CONST);

    logic [DATA_WIDTH-1:0] w_val_in;
    logic                  w_adv;

    // Stage 1 combinational
    fp16_t       w_op;
    logic        w_val_big;
    logic [4:0]  w_big_exp, w_sml_exp, w_big_e, w_sml_e, w_diff;
    logic [9:0]  w_big_man, w_sml_man;
    logic [10:0] w_big_sig, w_sml_sig;
    logic [27:0] w_wide;
    logic [13:0] w_sig_b;
    logic        w_spec;
    logic [15:0] w_spec_val;

    // Stage 1 registers
    logic        r_s1_valid, r_s1_sign, r_s1_sub, r_s1_spec;
    logic [4:0]  r_s1_exp;
    logic [13:0] r_s1_sig_a, r_s1_sig_b;
    logic [15:0] r_s1_spec_val;

    // Stage 2 combinational
    logic [14:0] w_sum;
    logic [3:0]  w_lzc;
    logic [5:0]  w_lim, w_sh, w_exp2;
    logic [13:0] w_sig2;

    // Stage 2 registers
    logic        r_s2_valid, r_s2_sign, r_s2_spec;
    logic [5:0]  r_s2_exp;
    logic [13:0] r_s2_sig;
    logic [15:0] r_s2_spec_val;

    // Stage 3 / output
    logic [15:0] w_packed;
    logic        r_res_valid;
    logic [15:0] r_res;

    assign w_val_in     = bus.val;
    assign w_adv        = !r_res_valid || bus.res_ready;
    assign bus.in_ready = w_adv;
    assign bus.res      = r_res;
    assign bus.res_valid = r_res_valid;

    // Stage 1: unpack, order by magnitude, align the smaller operand, flag specials.
    always_comb begin
        w_op      = fp16_t'(w_val_in);
        w_val_big = (w_val_in[14:0] >= ADD_CONST[14:0]);
        w_big_exp = w_val_big ? w_op.exp : c_k.exp;
        w_big_man = w_val_big ? w_op.man : c_k.man;
        w_sml_exp = w_val_big ? c_k.exp  : w_op.exp;
        w_sml_man = w_val_big ? c_k.man  : w_op.man;
        w_big_e   = (w_big_exp == 5'd0) ? 5'd1 : w_big_exp;
        w_sml_e   = (w_sml_exp == 5'd0) ? 5'd1 : w_sml_exp;
        w_big_sig = {w_big_exp != 5'd0, w_big_man};
        w_sml_sig = {w_sml_exp != 5'd0, w_sml_man};
        w_diff    = w_big_e - w_sml_e;
        w_wide    = {w_sml_sig, 17'd0} >> w_diff;
        w_sig_b   = (w_diff >= 5'd14) ? {13'd0, |w_sml_sig}
                                      : {w_wide[27:15], |w_wide[14:0]};
        w_spec     = 1'b0;
        w_spec_val = 16'h0000;
        if (fp16_is_nan(w_op)) begin
            w_spec     = 1'b1;
            w_spec_val = FP16_QNAN;
        end else if (w_op.exp == '1) begin
            w_spec     = 1'b1;
            w_spec_val = w_val_in;
        end else if ((w_op.sign != c_k.sign) && (w_val_in[14:0] == ADD_CONST[14:0])) begin
            // Exact cancellation (including -0 + +0) always yields +0.
            w_spec     = 1'b1;
            w_spec_val = 16'h0000;
        end
    end

    // Stage 1 register: captures a new operand whenever the pipe advances.
    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            r_s1_valid    <= 1'b0;
            r_s1_sign     <= 1'b0;
            r_s1_sub      <= 1'b0;
            r_s1_exp      <= 5'd0;
            r_s1_sig_a    <= 14'd0;
            r_s1_sig_b    <= 14'd0;
            r_s1_spec     <= 1'b0;
            r_s1_spec_val <= 16'h0000;
        end else if (w_adv) begin
            r_s1_valid    <= bus.en_add;
            r_s1_sign     <= w_val_big ? w_op.sign : c_k.sign;
            r_s1_sub      <= w_op.sign ^ c_k.sign;
            r_s1_exp      <= w_big_e;
            r_s1_sig_a    <= {w_big_sig, 3'b000};
            r_s1_sig_b    <= w_sig_b;
            r_s1_spec     <= w_spec;
            r_s1_spec_val <= w_spec_val;
        end
    end

    // Stage 2: add or subtract magnitudes, then normalise (carry right, zeros left).
    always_comb begin
        w_sum  = r_s1_sub ? ({1'b0, r_s1_sig_a} - {1'b0, r_s1_sig_b})
                          : ({1'b0, r_s1_sig_a} + {1'b0, r_s1_sig_b});
        w_lzc  = 4'd14;
        for (int i = 0; i < 14; i++) begin
            if (w_sum[i]) w_lzc = 4'(13 - i);
        end
        w_lim  = {1'b0, r_s1_exp} - 6'd1;
        w_sh   = 6'd0;
        w_sig2 = w_sum[13:0];
        w_exp2 = {1'b0, r_s1_exp};
        if (w_sum[14]) begin
            w_sig2 = {w_sum[14:2], w_sum[1] | w_sum[0]};
            w_exp2 = {1'b0, r_s1_exp} + 6'd1;
        end else begin
            // Stop at exponent 1 so tiny results come out subnormal.
            w_sh   = ({2'b00, w_lzc} > w_lim) ? w_lim : {2'b00, w_lzc};
            w_sig2 = w_sum[13:0] << w_sh;
            w_exp2 = {1'b0, r_s1_exp} - w_sh;
        end
    end

    // Stage 2 register: holds the normalised sum for rounding.
    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            r_s2_valid    <= 1'b0;
            r_s2_sign     <= 1'b0;
            r_s2_exp      <= 6'd0;
            r_s2_sig      <= 14'd0;
            r_s2_spec     <= 1'b0;
            r_s2_spec_val <= 16'h0000;
        end else if (w_adv) begin
            r_s2_valid    <= r_s1_valid;
            r_s2_sign     <= r_s1_sign;
            r_s2_exp      <= w_exp2;
            r_s2_sig      <= w_sig2;
            r_s2_spec     <= r_s1_spec;
            r_s2_spec_val <= r_s1_spec_val;
        end
    end

    fp16_round_pack u_round_pack (
        .i_sign     (r_s2_sign),
        .i_exp      (r_s2_exp),
        .i_sig      (r_s2_sig),
        .i_spec     (r_s2_spec),
        .i_spec_val (r_s2_spec_val),
        .o_res      (w_packed)
    );

    // Stage 3 register: the result stays put while downstream stalls.
    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            r_res_valid <= 1'b0;
            r_res       <= 16'h0000;
        end else if (w_adv) begin
            r_res_valid <= r_s2_valid;
            r_res       <= w_packed;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fp16_adds_const.sv
`default_nettype none
// ============================================================================
// Module      : tb_fp16_adds_const
// Description : Scoreboard bench for fp16_adds_const (ADD_CONST = 2.0).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fp16_adds_const;

    typedef struct {
        logic [15:0] val;
        int          cyc;
        bit          chk_lat;
    } exp_t;

    logic clk = 1'b0;
    logic reset_l = 1'b0;
    always #5 clk = ~clk;

    fp16_adds_const_if #(.DATA_WIDTH(16)) bus_if ();

    fp16_adds_const #(.DATA_WIDTH(16), .ADD_CONST(16'h4000)) dut (
        .clk     (clk),
        .reset_l (reset_l),
        .bus     (bus_if)
    );

    exp_t        sb[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    int          cyc     = 0;
    logic [15:0] cur_exp = 16'h0;
    bit          cur_lat = 1'b0;
    bit          acc_flag = 1'b0;
    bit          prev_stall = 1'b0;
    logic [15:0] prev_res = 16'h0;
    logic [15:0] vin  [15];
    logic [15:0] vout [15];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: push accepted operands, check transfers and stall behaviour.
    always @(negedge clk) begin
        if (!reset_l) begin
            prev_stall = 1'b0;
            acc_flag   = 1'b0;
        end else begin
            acc_flag = bus_if.en_add && bus_if.in_ready;
            if (acc_flag) sb.push_back('{cur_exp, cyc + 1, cur_lat});
            if (prev_stall) begin
                chk("res_hold", bus_if.res, prev_res);
                chk("valid_hold", bus_if.res_valid, 1);
            end
            if (bus_if.res_valid && !bus_if.res_ready)
                chk("in_ready_stall", bus_if.in_ready, 0);
            if (bus_if.res_valid && bus_if.res_ready) begin
                if (sb.size() == 0) begin
                    chk("extra_out", sb.size(), 1);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("res", bus_if.res, e.val);
                    if (e.chk_lat) chk("latency", cyc + 1 - e.cyc, 3);
                end
            end
            prev_stall = bus_if.res_valid && !bus_if.res_ready;
            prev_res   = bus_if.res;
        end
    end

    task automatic send(input logic [15:0] v, input logic [15:0] e, input bit lat);
        int guard;
        guard = 0;
        bus_if.en_add = 1'b1;
        bus_if.val    = v;
        cur_exp       = e;
        cur_lat       = lat;
        do begin
            @(posedge clk);
            #1;
            guard++;
        end while (!acc_flag && guard < 50);
        if (!acc_flag) chk("accept", acc_flag, 1);
        bus_if.en_add = 1'b0;
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while (sb.size() != 0 && guard < 100) begin
            @(posedge clk);
            guard++;
        end
        #1;
        chk("drain", sb.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vin = '{16'h3C00, 16'h3800, 16'hC000, 16'h6800, 16'h6C00, 16'h6C01, 16'h7BFF, 16'h7C00,
                16'hFC00, 16'h7E01, 16'hFE00, 16'hBC00, 16'hC200, 16'h0001, 16'h8000};
        vout = '{16'h4200, 16'h4100, 16'h0000, 16'h6801, 16'h6C00, 16'h6C02, 16'h7BFF, 16'h7C00,
                 16'hFC00, 16'h7E00, 16'h7E00, 16'h3C00, 16'hBC00, 16'h4000, 16'h4000};
        bus_if.en_add    = 1'b0;
        bus_if.val       = 16'h0;
        bus_if.res_ready = 1'b1;

        #12;
        chk("rst_res_valid", bus_if.res_valid, 0);
        chk("rst_res", bus_if.res, 16'h0000);
        chk("rst_in_ready", bus_if.in_ready, 1);
        @(negedge clk);
        #2 reset_l = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Directed values, unstalled, latency checked.
        for (int i = 0; i < 15; i++) send(vin[i], vout[i], 1'b1);
        drain();

        // Backpressure: 8 back-to-back operands with a 5-cycle stall mid-stream.
        fork
            for (int i = 0; i < 8; i++) send(vin[i], vout[i], 1'b0);
            begin
                repeat (4) @(posedge clk);
                #1 bus_if.res_ready = 1'b0;
                repeat (5) @(posedge clk);
                #1 bus_if.res_ready = 1'b1;
            end
        join
        drain();

        // Asynchronous reset with three operands in flight.
        for (int i = 0; i < 3; i++) send(vin[i], vout[i], 1'b0);
        #2 reset_l = 1'b0;
        #1;
        chk("rst_mid_valid", bus_if.res_valid, 0);
        chk("rst_mid_res", bus_if.res, 16'h0000);
        sb.delete();
        @(negedge clk);
        @(negedge clk);
        #2 reset_l = 1'b1;
        @(posedge clk);
        #1;
        send(16'h3C00, 16'h4200, 1'b1);
        drain();
        repeat (10) @(posedge clk);
        #1;
        chk("sb_empty", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
